// File: rtl/mont_prep_mod.sv
// mont_prep_mod: computes T = Y*2^WIDTH mod N by modular doubling; define PREP_RADIX4_EN for two bits per cycle
module mont_prep_mod #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] N_out,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] t_nxt;
`ifdef PREP_RADIX4_EN
  localparam int ITERS = WIDTH / 2;
  logic [WIDTH:0]   n2;
  logic [WIDTH+1:0] n3;
  logic [WIDTH+2:0] q, m;
  // largest multiple of N not exceeding 4T, so the remainder stays below N
  always_comb begin
    q = {1'b0, T, 2'b00};
    m = q >= {1'b0, n3} ? {1'b0, n3} :
        q >= {2'b0, n2} ? {2'b0, n2} :
        q >= {3'b0, N_out} ? {3'b0, N_out} : '0;
    t_nxt = WIDTH'(q - m);
  end
`else
  localparam int ITERS = WIDTH;
  logic [WIDTH+1:0] d;
  always_comb begin
    d = {1'b0, T, 1'b0};
    t_nxt = WIDTH'(d >= {2'b0, N_out} ? d - {2'b0, N_out} : d);
  end
`endif
  assign busy = state == S_CALC;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S_IDLE;
      T     <= '0;
      N_out <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef PREP_RADIX4_EN
      n2    <= '0;
      n3    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        T     <= Y;
        N_out <= N;
        cnt   <= '0;
        state <= S_CALC;
`ifdef PREP_RADIX4_EN
        n2    <= {N, 1'b0};
        n3    <= {1'b0, N, 1'b0} + {2'b0, N};
`endif
      end else if (state == S_CALC) begin
        T     <= t_nxt;
        cnt   <= cnt + CNT_W'(1);
        state <= cnt == CNT_W'(ITERS - 1) ? S_DONE : S_CALC;
      end else if (state == S_DONE) begin
        done  <= 1'b1;
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: doc/mont_prep_mod.md
Name: mont_prep_mod

Overview:
- Upstream pre-processing stage for the radix-4 Montgomery multiplier in the RSA datapath.
- Converts an operand into the Montgomery domain: T = Y * 2^WIDTH mod N.
- Uses iterative modular doubling, one or two bits per cycle.
- T feeds the multiplier's A/B inputs. N passes through unchanged to the multiplier.

Parameters:
- WIDTH, 256, operand and modulus width in bits.
- CNT_W, 9, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- rst_n  input  1  synchronous reset, active-high: asserted (1) resets the block on the next rising clk edge.
- start  input  1  request pulse; sampled only in IDLE.
- Y  input  WIDTH  operand; precondition Y < N.
- N  input  WIDTH  modulus; precondition N odd, N > 2.
- T  output  WIDTH  result Y*2^WIDTH mod N; held stable from done until the next accepted start.
- N_out  output  WIDTH  latched modulus, stable while busy and after done.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when T is valid.

Behaviour:
- Single clock domain. Reset is synchronous, active-high on rst_n.
- Reset values: state=IDLE, T=0, N_out=0, busy=0, done=0, counter=0.
- States:
  - IDLE: on start=1, latch T<=Y and N_out<=N, counter<=0, go to CALC.
  - CALC: each cycle compute D = 2*T in WIDTH+1 bits. If D >= N_out then T <= D - N_out, else T <= D. Increment counter. After the WIDTH-th iteration (counter = WIDTH-1 this cycle), go to DONE.
  - DONE: done=1 for exactly this cycle, then return to IDLE.
- busy=1 exactly while in CALC.
- Latency (default build): start sampled at edge 0; CALC occupies edges 1..WIDTH; done high in the cycle after edge WIDTH+1, i.e. 257 cycles after start for WIDTH=256.
- Width rules:
  - All intermediates are WIDTH+2 bits; no truncation before comparison.
  - The invariant T < N_out holds after every iteration.
  - T output is the low WIDTH bits, whose upper guard bits are always zero.
- start while busy or in DONE: ignored. No queueing, and inputs are not re-latched.
- Y and N may change freely after the start cycle; only the latched copies are used.
- rst_n asserted mid-CALC: abort next edge and apply the reset values. done must not pulse.
- start and rst_n together: reset wins.
- Precondition violations (Y >= N, N even): the result is undefined, but the FSM must still terminate with the standard latency.

Optional Feature:
- Macro PREP_RADIX4_EN.
- Defined:
  - Two bits per CALC cycle. Compute Q = 4*T in WIDTH+3 bits, then subtract the largest of {0, N, 2N, 3N} that keeps the result >= 0.
  - Use parallel comparators against precomputed 2N and 3N, registered in IDLE on start.
  - The counter advances by 1 and terminates after WIDTH/2 iterations, so done arrives 129 cycles after start for WIDTH=256.
  - WIDTH must be even.
- Undefined: the radix-2 datapath above, with no 2N/3N registers.
- Results are bit-identical in both builds.

Test Plan:
- Y=1, N=13, start pulse → done after 257 cycles (129 with PREP_RADIX4_EN), T=3, busy high throughout CALC.
- Y=5, N=13 → T=2. Y=0, N=13 → T=0.
- Y=1, N=2^255+1 → T=2^255-1. Y=2^255, N=2^255+1 → T=2. This exercises the top-bit guard and subtract paths.
- During CALC of Y=1, N=13, pulse start with Y=7, N=11 → ignored, result still T=3. A new start after done with Y=7, N=11 → T = 7*2^256 mod 11 = 7*(2^256 mod 11) = 7*9 mod 11 = 8.
- Assert rst_n for 1 cycle at CALC iteration 100 → next cycle T=0, busy=0, N_out=0, no done. A fresh start then completes normally with the full latency.
- Random regression: 500 random odd N with MSB set and random Y<N, checked against a bignum model of Y*2^256 mod N in both macro builds.
